// File: rtl/dot_matrix_scan_ctrl.sv
// Double-buffered row-scan controller for a ROWS x COLS LED dot matrix.
// Optional column blanking at row start is enabled by defining GHOST_BLANK_EN.
module dot_matrix_scan_ctrl #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DIV            = 25000,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter int BLANK          = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic [ROWS-1:0]         dot_row,
  output logic [COLS-1:0]         dot_col,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(DIV);

  if (ROWS < 2 || COLS < 1 || DIV < 2 || BLANK >= DIV) begin : g_bad_params
    $error("dot_matrix_scan_ctrl: illegal parameter combination");
  end

  logic [CW-1:0]   cnt;
  logic            tick;
  logic [COLS-1:0] bank [2][ROWS];
  logic            front_sel;
  logic [RW-1:0]   row_q;
  logic [ROWS-1:0] row_pat_q;
  logic [COLS-1:0] col_q;
  logic            fs_q;
  logic            ack_q;

  logic            wrap;
  logic            do_swap;
  logic            next_sel;
  logic            wr_ok;
  logic [RW-1:0]   next_row;
  logic [COLS-1:0] next_col;
  logic [ROWS-1:0] onehot;

  assign tick = (cnt == CW'(DIV - 1));

  always_comb begin
    wrap     = (row_q == RW'(ROWS - 1));
    next_row = wrap ? '0 : row_q + RW'(1);
    do_swap  = tick && wrap && swap_req;
    next_sel = front_sel ^ do_swap;
    wr_ok    = wr_en && ({1'b0, wr_row} < (RW + 1)'(ROWS));
    next_col = bank[next_sel][next_row];
    // A write on the swap edge targets the buffer that is becoming front,
    // so forward it when it hits the row being loaded right now.
    if (do_swap && wr_ok && (wr_row == next_row))
      next_col = wr_data;
    onehot   = {1'b1, {(ROWS - 1){1'b0}}} >> next_row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        bank[0][r] <= '0;
        bank[1][r] <= '0;
      end
    end else if (wr_ok) begin
      bank[~front_sel][wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front_sel <= 1'b0;
      row_q     <= RW'(ROWS - 1);
      row_pat_q <= {ROWS{ROW_ACTIVE_LOW}};
      col_q     <= '0;
      fs_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      fs_q  <= 1'b0;
      ack_q <= 1'b0;
      if (tick) begin
        front_sel <= next_sel;
        row_q     <= next_row;
        row_pat_q <= onehot ^ {ROWS{ROW_ACTIVE_LOW}};
        col_q     <= next_col;
        fs_q      <= wrap;
        ack_q     <= do_swap;
      end
    end
  end

  assign dot_row     = row_pat_q;
  assign row_idx     = row_q;
  assign frame_start = fs_q;
  assign swap_ack    = ack_q;

`ifdef GHOST_BLANK_EN
  // cnt restarts at 0 in the cycle the new strobe appears.
  assign dot_col = (cnt < CW'(BLANK)) ? '0 : col_q;
`else
  assign dot_col = col_q;
`endif

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Directed self-checking bench for dot_matrix_scan_ctrl (8x8 and 10x4 builds).
module tb_dot_matrix_scan_ctrl;

`ifdef GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic [7:0] dot_row;
  logic [7:0] dot_col;
  logic [2:0] row_idx;
  logic       frame_start;

  logic       reset10;
  logic       wr_en10;
  logic [3:0] wr_row10;
  logic [3:0] wr_data10;
  logic       swap_req10;
  logic       swap_ack10;
  logic [9:0] dot_row10;
  logic [3:0] dot_col10;
  logic [3:0] row_idx10;
  logic       frame_start10;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] row_tab [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] frame_b [8] = '{8'hA5, 8'hFF, 8'h00, 8'h3C, 8'h00, 8'h5A, 8'h00, 8'h00};

  always #5 clk = ~clk;

  dot_matrix_scan_ctrl #(
    .ROWS(8), .COLS(8), .DIV(4), .ROW_ACTIVE_LOW(1'b1), .BLANK(2)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .dot_row(dot_row), .dot_col(dot_col),
    .row_idx(row_idx), .frame_start(frame_start)
  );

  dot_matrix_scan_ctrl #(
    .ROWS(10), .COLS(4), .DIV(2), .ROW_ACTIVE_LOW(1'b1), .BLANK(1)
  ) dut10 (
    .clk(clk), .reset(reset10), .wr_en(wr_en10), .wr_row(wr_row10), .wr_data(wr_data10),
    .swap_req(swap_req10), .swap_ack(swap_ack10), .dot_row(dot_row10), .dot_col(dot_col10),
    .row_idx(row_idx10), .frame_start(frame_start10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at the negedge right after a tick (prescaler at 0); returns at prescaler 3.
  task automatic row_period(input int r, input logic [7:0] col, input logic fs, input logic ack);
    check($sformatf("row%0d_idx", r), row_idx, r);
    check($sformatf("row%0d_strobe", r), dot_row, row_tab[r]);
    check($sformatf("row%0d_fs", r), frame_start, fs);
    check($sformatf("row%0d_ack", r), swap_ack, ack);
    check($sformatf("row%0d_col_c0", r), dot_col, GHOST ? 8'h00 : col);
    wait_neg(1);
    check($sformatf("row%0d_col_c1", r), dot_col, GHOST ? 8'h00 : col);
    check($sformatf("row%0d_fs_c1", r), frame_start, 1'b0);
    check($sformatf("row%0d_ack_c1", r), swap_ack, 1'b0);
    wait_neg(1);
    check($sformatf("row%0d_col_c2", r), dot_col, col);
    wait_neg(1);
    check($sformatf("row%0d_col_c3", r), dot_col, col);
    check($sformatf("row%0d_strobe_c3", r), dot_row, row_tab[r]);
    check($sformatf("row%0d_idx_c3", r), row_idx, r);
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
  endtask

  initial begin
    logic ack_seen;
    reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
    reset10 = 1'b0; wr_en10 = 1'b0; wr_row10 = '0; wr_data10 = '0; swap_req10 = 1'b0;
    wait_neg(3);
    check("rst_strobe", dot_row, 8'hFF);
    check("rst_col", dot_col, 8'h00);
    check("rst_idx", row_idx, 3'd7);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ack", swap_ack, 1'b0);

    reset = 1'b1;
    write_row(3'd0, 8'hA5);
    wait_neg(1);
    wr_en = 1'b0;
    wait_neg(2);
    check("pre_tick_strobe", dot_row, 8'hFF);
    check("pre_tick_col", dot_col, 8'h00);
    check("pre_tick_idx", row_idx, 3'd7);
    check("pre_tick_fs", frame_start, 1'b0);
    wait_neg(1);

    // Frame A: front empty, fill back buffer, request swap at end.
    for (int r = 0; r < 8; r++) begin
      if (r > 0) begin
        wait_neg(1);
        wr_en = 1'b0;
      end
      row_period(r, 8'h00, r == 0, 1'b0);
      if (r == 0) write_row(3'd1, 8'hFF);
      if (r == 2) write_row(3'd5, 8'h5A);
      if (r == 7) begin
        swap_req = 1'b1;
        write_row(3'd3, 8'h3C);
      end
    end

    // Frame B: swapped in, swap_req stays high.
    for (int r = 0; r < 8; r++) begin
      wait_neg(1);
      wr_en = 1'b0;
      row_period(r, frame_b[r], r == 0, r == 0);
    end

    // Frame C: second swap brings back the empty buffer.
    for (int r = 0; r < 8; r++) begin
      wait_neg(1);
      row_period(r, 8'h00, r == 0, r == 0);
      if (r == 0) swap_req = 1'b0;
      if (r == 3) write_row(3'd2, 8'h22);
      if (r == 4) wr_en = 1'b0;
    end

    // Frame D: no swap, back-buffer write stays hidden; reset during row 5.
    for (int r = 0; r < 5; r++) begin
      wait_neg(1);
      row_period(r, 8'h00, r == 0, 1'b0);
    end
    wait_neg(1);
    check("d_row5_idx", row_idx, 3'd5);
    swap_req = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    #1;
    check("midrst_strobe", dot_row, 8'hFF);
    check("midrst_col", dot_col, 8'h00);
    check("midrst_idx", row_idx, 3'd7);
    check("midrst_fs", frame_start, 1'b0);
    check("midrst_ack", swap_ack, 1'b0);
    wait_neg(2);
    reset = 1'b1;
    swap_req = 1'b0;
    wait_neg(3);
    check("post_rst_idx", row_idx, 3'd7);
    check("post_rst_strobe", dot_row, 8'hFF);
    check("post_rst_fs", frame_start, 1'b0);
    wait_neg(1);
    row_period(0, 8'h00, 1'b1, 1'b0);

    // 10-row build: out-of-range writes dropped, row 9 valid.
    reset10 = 1'b1;
    wr_en10 = 1'b1; wr_row10 = 4'd9;  wr_data10 = 4'h9;
    wait_neg(1);
    wr_row10 = 4'd10; wr_data10 = 4'hF;
    wait_neg(1);
    wr_row10 = 4'd15; wr_data10 = 4'hF;
    wait_neg(1);
    wr_en10 = 1'b0;
    swap_req10 = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 100 && !ack_seen; i++) begin
      @(negedge clk);
      ack_seen = swap_ack10;
    end
    check("r10_ack_seen", ack_seen, 1'b1);
    swap_req10 = 1'b0;
    for (int r = 0; r < 10; r++) begin
      logic [9:0] strobe;
      strobe = ~(10'h200 >> r);
      check($sformatf("r10_row%0d_idx", r), row_idx10, r);
      check($sformatf("r10_row%0d_strobe", r), dot_row10, strobe);
      check($sformatf("r10_row%0d_fs", r), frame_start10, r == 0);
      wait_neg(1);
      check($sformatf("r10_row%0d_col", r), dot_col10, (r == 9) ? 4'h9 : 4'h0);
      wait_neg(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
